// File: rtl/play_recorder.sv
// play_recorder
//   Capture stage in front of the record storage manager. While recording,
//   each new key press (a rising edge on the debounced key vector) is stored
//   in the event buffer together with the current tick timestamp. When
//   recording ends, the finished record is held steady and a one-cycle write
//   request carries the slot id. Slot ids are handed out round-robin,
//   1..RECS_MAX. A write id of 0 means "no write"; id n writes slot n-1.
//
// Ports
//   clk             system clock
//   sys_rst_n       asynchronous active-low reset
//   start           one-cycle pulse, begin recording (accepted in IDLE only)
//   stop            one-cycle pulse, end recording (honoured in REC only)
//   tick            one-cycle time-base strobe
//   keys            debounced key levels, 1 = pressed
//   record_events   EVENTS_MAX packed entries of {mask, ts}, entry 0 at the LSBs
//   record_count    number of valid entries in record_events
//   write_record_id slot id, nonzero only during the COMMIT cycle
//   recording       high while in REC
//   buf_full        record_count == EVENTS_MAX
module play_recorder #(
  parameter int KEYS       = 7,
  parameter int EVENTS_MAX = 16,
  parameter int TS_W       = 16,
  parameter int RECS_MAX   = 8
) (
  input  logic                                  clk,
  input  logic                                  sys_rst_n,
  input  logic                                  start,
  input  logic                                  stop,
  input  logic                                  tick,
  input  logic [KEYS-1:0]                       keys,
  output logic [EVENTS_MAX*(KEYS+TS_W)-1:0]     record_events,
  output logic [$clog2(EVENTS_MAX+1)-1:0]       record_count,
  output logic [7:0]                            write_record_id,
  output logic                                  recording,
  output logic                                  buf_full
);

  localparam int EW = KEYS + TS_W;
  localparam int CW = $clog2(EVENTS_MAX + 1);
  localparam logic [CW-1:0] MAX_COUNT  = CW'(EVENTS_MAX);
  localparam logic [CW-1:0] LAST_COUNT = CW'(EVENTS_MAX - 1);
  localparam logic [7:0]    LAST_SLOT  = 8'(RECS_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REC    = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [KEYS-1:0] keys_q;
  logic [KEYS-1:0] new_keys;
  logic [TS_W-1:0] ts;
  logic [CW-1:0]   count;
  logic [7:0]      next_slot;
  logic            store;

  // Keys that went from released to pressed since the previous cycle.
  assign new_keys = keys & ~keys_q;

  // An event is stored only while recording and only if the buffer has room;
  // presses arriving on a full buffer are dropped.
  assign store = (state == REC) && (new_keys != '0) && (count < MAX_COUNT);

  assign record_count = count;
  assign buf_full     = (count == MAX_COUNT);

  // State register.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. Recording ends on stop, or on the edge that stores the
  // last event the buffer can hold, whichever comes first.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = REC;
        end
      end
      REC: begin
        if (stop || (store && (count == LAST_COUNT))) begin
          state_next = COMMIT;
        end
      end
      COMMIT: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath. keys_q follows keys in every state, so keys already held when
  // start arrives never show up as new presses. write_record_id and
  // recording are loaded from the next state so they line up exactly with
  // the COMMIT and REC cycles.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      keys_q          <= '0;
      ts              <= '0;
      count           <= '0;
      record_events   <= '0;
      write_record_id <= 8'd0;
      next_slot       <= 8'd1;
      recording       <= 1'b0;
    end else begin
      keys_q          <= keys;
      write_record_id <= (state_next == COMMIT) ? next_slot : 8'd0;
      recording       <= (state_next == REC);
      case (state)
        IDLE: begin
          if (start) begin
            ts            <= '0;
            count         <= '0;
            record_events <= '0;
          end
        end
        REC: begin
          // Saturating timestamp; an event stored on a tick cycle sees the
          // pre-increment value because both use the current ts.
          if (tick && (ts != '1)) begin
            ts <= ts + TS_W'(1);
          end
          if (store) begin
            record_events[int'(count)*EW +: EW] <= {new_keys, ts};
            count <= count + CW'(1);
          end
        end
        COMMIT: begin
          next_slot <= (next_slot == LAST_SLOT) ? 8'd1 : next_slot + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_play_recorder.sv
// tb_play_recorder
//   Self-checking bench for play_recorder with default parameters
//   (KEYS=7, EVENTS_MAX=16, TS_W=16, RECS_MAX=8). A vector table covers a
//   basic record session; hand-written sequences cover held keys,
//   simultaneous presses, buffer overflow, slot wrap and reset abort.
module tb_play_recorder;

  localparam int KEYS = 7;
  localparam int EVENTS_MAX = 16;
  localparam int TS_W = 16;
  localparam int EW = KEYS + TS_W;

  logic                          clk;
  logic                          sys_rst_n;
  logic                          start;
  logic                          stop;
  logic                          tick;
  logic [KEYS-1:0]               keys;
  logic [EVENTS_MAX*EW-1:0]      record_events;
  logic [4:0]                    record_count;
  logic [7:0]                    write_record_id;
  logic                          recording;
  logic                          buf_full;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic            s;
    logic            p;
    logic            t;
    logic [KEYS-1:0] k;
    logic            rec;
    logic [4:0]      cnt;
    logic [7:0]      wid;
    logic            full;
  } vec_t;

  vec_t vecs[$];

  play_recorder dut (
    .clk             (clk),
    .sys_rst_n       (sys_rst_n),
    .start           (start),
    .stop            (stop),
    .tick            (tick),
    .keys            (keys),
    .record_events   (record_events),
    .record_count    (record_count),
    .write_record_id (write_record_id),
    .recording       (recording),
    .buf_full        (buf_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle of inputs, let the edge happen, then release the pulses.
  // Outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic s, input logic p, input logic t,
                               input logic [KEYS-1:0] k);
    start = s;
    stop  = p;
    tick  = t;
    keys  = k;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [EW-1:0] entry_at(input int i);
    return record_events[i*EW +: EW];
  endfunction

  function automatic logic [EW-1:0] ev(input logic [KEYS-1:0] m, input int t);
    return {m, TS_W'(t)};
  endfunction

  function automatic vec_t mk(input logic s, input logic p, input logic t,
                              input logic [KEYS-1:0] k, input logic rec,
                              input int cnt, input int wid, input logic full);
    vec_t v;
    v.s = s; v.p = p; v.t = t; v.k = k;
    v.rec = rec; v.cnt = 5'(cnt); v.wid = 8'(wid); v.full = full;
    return v;
  endfunction

  initial begin
    logic [7:0] exp_slot;
    tests_run    = 0;
    tests_failed = 0;
    sys_rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    tick  = 1'b0;
    keys  = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset.recording", recording, 0);
    checkOutput("reset.count", record_count, 0);
    checkOutput("reset.wid", write_record_id, 0);
    checkOutput("reset.buf_full", buf_full, 0);
    checkOutput("reset.events_nonzero", record_events != '0, 0);
    sys_rst_n = 1'b1;
    applyStimulus(0, 0, 0, '0);

    // Session 1: key 2 after 5 ticks, key 0 after 9 ticks, stop.
    vecs.push_back(mk(1, 0, 0, 7'b0000000, 1, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 1, 7'b0000000, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 7'b0000100, 1, 1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 1, 7'b0000100, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 7'b0000101, 1, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 7'b0000101, 0, 2, 1, 0));
    vecs.push_back(mk(0, 0, 0, 7'b0000101, 0, 2, 0, 0));
    vecs.push_back(mk(0, 1, 0, 7'b0000000, 0, 2, 0, 0));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].s, vecs[i].p, vecs[i].t, vecs[i].k);
      checkOutput($sformatf("vec%0d.recording", i), recording, vecs[i].rec);
      checkOutput($sformatf("vec%0d.count", i), record_count, vecs[i].cnt);
      checkOutput($sformatf("vec%0d.wid", i), write_record_id, vecs[i].wid);
      checkOutput($sformatf("vec%0d.buf_full", i), buf_full, vecs[i].full);
    end
    checkOutput("s1.entry0", entry_at(0), ev(7'b0000100, 5));
    checkOutput("s1.entry1", entry_at(1), ev(7'b0000001, 9));
    checkOutput("s1.entry2", entry_at(2), 0);

    // Session 2: key 3 held through start is not logged; re-press at ts 4.
    applyStimulus(0, 0, 0, 7'b0001000);
    applyStimulus(1, 0, 0, 7'b0001000);
    checkOutput("s2.start_count", record_count, 0);
    checkOutput("s2.start_entry0", entry_at(0), 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1, 7'b0001000);
    checkOutput("s2.held_count", record_count, 0);
    applyStimulus(0, 0, 0, 7'b0000000);
    applyStimulus(0, 0, 0, 7'b0001000);
    checkOutput("s2.count", record_count, 1);
    checkOutput("s2.entry0", entry_at(0), ev(7'b0001000, 4));
    applyStimulus(0, 1, 0, 7'b0001000);
    checkOutput("s2.wid", write_record_id, 2);
    applyStimulus(0, 0, 0, 7'b0000000);
    checkOutput("s2.wid_after", write_record_id, 0);

    // Session 3: simultaneous presses, press with tick, press with stop.
    applyStimulus(1, 0, 0, 7'b0000000);
    start = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 7'b0000000);
    applyStimulus(0, 0, 0, 7'b0100010);
    checkOutput("s3.count1", record_count, 1);
    checkOutput("s3.entry0", entry_at(0), ev(7'b0100010, 3));
    applyStimulus(0, 0, 1, 7'b1100010);
    checkOutput("s3.entry1_pretick", entry_at(1), ev(7'b1000000, 3));
    applyStimulus(0, 1, 0, 7'b1100011);
    checkOutput("s3.stop_count", record_count, 3);
    checkOutput("s3.entry2_with_stop", entry_at(2), ev(7'b0000001, 4));
    checkOutput("s3.wid", write_record_id, 3);
    checkOutput("s3.recording", recording, 0);
    applyStimulus(0, 0, 0, 7'b0000000);
    checkOutput("s3.wid_after", write_record_id, 0);

    // Session 4: 17 presses, auto-commit after the 16th, 17th dropped.
    applyStimulus(1, 0, 0, 7'b0000000);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(0, 0, 0, 7'(1 << (i % 7)));
      if (i < 15) begin
        checkOutput($sformatf("s4.count%0d", i), record_count, i + 1);
        checkOutput($sformatf("s4.wid%0d", i), write_record_id, 0);
      end else if (i == 15) begin
        checkOutput("s4.full_count", record_count, 16);
        checkOutput("s4.buf_full", buf_full, 1);
        checkOutput("s4.auto_wid", write_record_id, 4);
        checkOutput("s4.recording", recording, 0);
      end else begin
        checkOutput("s4.dropped_count", record_count, 16);
        checkOutput("s4.dropped_wid", write_record_id, 0);
      end
      applyStimulus(0, 0, 1, 7'b0000000);
      if (i == 15) checkOutput("s4.wid_after", write_record_id, 0);
    end
    checkOutput("s4.entry0", entry_at(0), ev(7'b0000001, 0));
    checkOutput("s4.entry15", entry_at(15), ev(7'b0000010, 15));

    // Nine empty sessions: slot ids 5,6,7,8,1,2,3,4,5.
    exp_slot = 8'd5;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1, 0, 0, 7'b0000000);
      checkOutput($sformatf("rr%0d.recording", i), recording, 1);
      checkOutput($sformatf("rr%0d.count", i), record_count, 0);
      applyStimulus(0, 1, 0, 7'b0000000);
      checkOutput($sformatf("rr%0d.wid", i), write_record_id, exp_slot);
      applyStimulus(0, 0, 0, 7'b0000000);
      checkOutput($sformatf("rr%0d.wid_after", i), write_record_id, 0);
      exp_slot = (exp_slot == 8'd8) ? 8'd1 : exp_slot + 8'd1;
    end

    // Reset during REC with 3 events: immediate clear, no write, slot 1 next.
    applyStimulus(1, 0, 0, 7'b0000000);
    applyStimulus(0, 0, 0, 7'b0000001);
    applyStimulus(0, 0, 0, 7'b0000011);
    applyStimulus(0, 0, 0, 7'b0000111);
    checkOutput("rst.pre_count", record_count, 3);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("rst.async_count", record_count, 0);
    checkOutput("rst.async_recording", recording, 0);
    checkOutput("rst.async_events_nonzero", record_events != '0, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 0, 7'b0000000);
      checkOutput($sformatf("rst.no_write%0d", i), write_record_id, 0);
    end
    sys_rst_n = 1'b1;
    applyStimulus(0, 0, 0, 7'b0000000);
    checkOutput("rst.idle_wid", write_record_id, 0);
    applyStimulus(1, 0, 0, 7'b0000000);
    applyStimulus(0, 1, 0, 7'b0000000);
    checkOutput("rst.next_slot", write_record_id, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
